adc_seq_ctrl: RTL and testbench

//  Conversion scheduler for the external ADC SPI link. On each trigger (PWM carrier sync pulse)
//  it walks the enabled channels in ascending order and issues one SPI command per channel.

---
 rtl/adc_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_ctrl.sv
// Conversion scheduler for the external ADC SPI link: walks enabled channels on each trigger.
// Optional ADC_SEQ_AVG_EN: two back-to-back samples per channel, the stored value is their mean.
module adc_seq_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 16,
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              trigger,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              abort,
  input  logic              overrun_clr,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_tx,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rx,
  output logic              result_valid,
  output logic [CH_W-1:0]   result_ch,
  output logic [DATA_W-1:0] result_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              seq_done,
  output logic              aborted,
  output logic              overrun
);

  localparam int unsigned IDX_W  = CH_W + 1;
  localparam int unsigned SLOT_N = 1 << CH_W;
  localparam int unsigned PAD_W  = DATA_W - 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_FIN
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    ch_idx_q;
  logic [SLOT_N-1:0]   mask_q;
  logic [DATA_W-1:0]   regs_q [SLOT_N];

  logic [CH_W-1:0]     ch_c;
  logic [DATA_W-1:0]   cmd_c;
  logic                store_en_c;
  logic [DATA_W-1:0]   store_val_c;

  assign ch_c    = ch_idx_q[CH_W-1:0];
  assign cmd_c   = {1'b1, 3'(ch_idx_q), {PAD_W{1'b0}}};
  assign rd_data = regs_q[rd_ch];

`ifdef ADC_SEQ_AVG_EN
  logic              second_q;
  logic [DATA_W-1:0] s0_q;
  logic [DATA_W:0]   sum_c;

  assign sum_c       = {1'b0, s0_q} + {1'b0, spi_rx};
  assign store_en_c  = spi_done & second_q;
  assign store_val_c = sum_c[DATA_W:1];

  // First-sample holding register; cleared whenever the sequence leaves the channel abnormally
  always_ff @(posedge clk) begin
    if (rst) begin
      second_q <= 1'b0;
      s0_q     <= '0;
    end else if (abort || state_q == S_IDLE) begin
      second_q <= 1'b0;
    end else if (state_q == S_WAIT && spi_done) begin
      second_q <= !second_q;
      if (!second_q) s0_q <= spi_rx;
    end
  end
`else
  assign store_en_c  = spi_done;
  assign store_val_c = spi_rx;
`endif

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ch_idx_q     <= '0;
      mask_q       <= '0;
      spi_start    <= 1'b0;
      spi_tx       <= '0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
      aborted      <= 1'b0;
      overrun      <= 1'b0;
      for (int unsigned i = 0; i < SLOT_N; i++) regs_q[i] <= '0;
    end else begin
      spi_start    <= 1'b0;
      result_valid <= 1'b0;
      seq_done     <= 1'b0;
      aborted      <= 1'b0;

      if (trigger && state_q != S_IDLE) overrun <= 1'b1;
      else if (overrun_clr)             overrun <= 1'b0;

      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (trigger && enable && !abort) begin
              if (|ch_mask) begin
                mask_q   <= SLOT_N'(ch_mask);
                ch_idx_q <= '0;
                busy     <= 1'b1;
                state_q  <= S_SCAN;
              end else begin
                seq_done <= 1'b1;
              end
            end
          end
          // Issue directly from SCAN when the link is free to meet the T+2 start latency
          S_SCAN: begin
            if (ch_idx_q == IDX_W'(NUM_CH)) begin
              seq_done <= 1'b1;
              busy     <= 1'b0;
              state_q  <= S_FIN;
            end else if (mask_q[ch_c]) begin
              if (!spi_busy) begin
                spi_start <= 1'b1;
                spi_tx    <= cmd_c;
                state_q   <= S_WAIT;
              end else begin
                state_q <= S_ISSUE;
              end
            end else begin
              ch_idx_q <= ch_idx_q + IDX_W'(1);
            end
          end
          S_ISSUE: begin
            if (!spi_busy) begin
              spi_start <= 1'b1;
              spi_tx    <= cmd_c;
              state_q   <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (store_en_c) begin
              result_valid  <= 1'b1;
              result_ch     <= ch_c;
              result_data   <= store_val_c;
              regs_q[ch_c]  <= store_val_c;
              state_q       <= S_STORE;
            end else if (spi_done) begin
              state_q <= S_ISSUE;
            end
          end
          S_STORE: begin
            ch_idx_q <= ch_idx_q + IDX_W'(1);
            state_q  <= S_SCAN;
          end
          S_FIN: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Self-checking bench for adc_seq_ctrl: vector table, randomized sequences, directed corner cases.
// An SPI responder answers each spi_start after a programmable latency from a word queue.
module tb_adc_seq_ctrl;

`ifdef ADC_SEQ_AVG_EN
  localparam int NS = 2;
`else
  localparam int NS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic [3:0]  ch_mask = 4'h0;
  logic        abort = 1'b0;
  logic        overrun_clr = 1'b0;
  logic        spi_start;
  logic [15:0] spi_tx;
  logic        spi_busy = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rx = 16'h0;
  logic        result_valid;
  logic [1:0]  result_ch;
  logic [15:0] result_data;
  logic [1:0]  rd_ch = 2'd0;
  logic [15:0] rd_data;
  logic        busy;
  logic        seq_done;
  logic        aborted;
  logic        overrun;

  adc_seq_ctrl #(.NUM_CH(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .trigger(trigger), .ch_mask(ch_mask),
    .abort(abort), .overrun_clr(overrun_clr), .spi_start(spi_start), .spi_tx(spi_tx),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx(spi_rx),
    .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data),
    .rd_ch(rd_ch), .rd_data(rd_data), .busy(busy), .seq_done(seq_done),
    .aborted(aborted), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder / monitor state
  int          cyc = 0;
  int          pend = 0;
  int          spi_lat = 3;
  logic [15:0] rx_q[$];
  logic [15:0] tx_log[$];
  int          tx_cyc[$];
  int          res_ch_log[$];
  logic [15:0] res_data_log[$];
  int          res_cyc[$];
  int          done_cyc[$];
  int          seq_done_cnt = 0;
  int          seq_done_cyc = -1;
  int          aborted_cnt = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    spi_done = 1'b0;
    if (spi_start) begin
      tx_log.push_back(spi_tx);
      tx_cyc.push_back(cyc);
      pend = spi_lat;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        spi_done = 1'b1;
        if (rx_q.size() > 0) spi_rx = rx_q.pop_front();
        else                 spi_rx = 16'hDEAD;
        done_cyc.push_back(cyc);
      end
    end
    if (result_valid === 1'b1) begin
      res_ch_log.push_back(int'(result_ch));
      res_data_log.push_back(result_data);
      res_cyc.push_back(cyc);
    end
    if (seq_done === 1'b1) begin
      seq_done_cnt++;
      seq_done_cyc = cyc;
    end
    if (aborted === 1'b1) aborted_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_reg(input int ch, input logic [15:0] exp, input string name);
    rd_ch = 2'(ch);
    #1;
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic clear_logs();
    rx_q.delete(); tx_log.delete(); tx_cyc.delete(); res_ch_log.delete();
    res_data_log.delete(); res_cyc.delete(); done_cyc.delete();
    seq_done_cnt = 0; seq_done_cyc = -1; aborted_cnt = 0;
  endtask

  task automatic wait_quiet(input string name);
    int k = 0;
    while ((busy !== 1'b0 || pend != 0 || spi_done) && k < 300) begin
      tick();
      k++;
    end
    tick(2);
    if (k >= 300) chk(name, 32'(k), 32'(0));
  endtask

  task automatic wait_tx(input int n, input string name);
    int k = 0;
    while (tx_log.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk(name, 32'(tx_log.size() >= n), 32'(1));
  endtask

  task automatic pulse_trigger(input logic [3:0] m, output int t);
    ch_mask = m;
    trigger = 1'b1;
    t = cyc;
    tick();
    trigger = 1'b0;
  endtask

  typedef struct {
    logic [3:0]       mask;
    logic [3:0][15:0] rx;
    int               exp_n;
    logic [15:0]      exp_tx0;
    logic [15:0]      exp_txl;
    logic [3:0][15:0] exp_reg;
  } vec_t;

  vec_t        tv[5];
  logic [15:0] model_reg[4];
  logic [15:0] exp_data[$];
  int          exp_ch[$];
  logic [15:0] exp_tx[$];
  int          t0;
  int          lo;
  int          hi;
  int          fall;
  logic [15:0] a;
  logic [15:0] b;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Vectors: rx[ch] is the word returned while converting ch; exp_reg is the cumulative reg file
    tv[0] = '{4'b1111, {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, 4, 16'h8000, 16'hB000,
              {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}};
    tv[1] = '{4'b1010, {16'h2222, 16'h0000, 16'h1111, 16'h0000}, 2, 16'h9000, 16'hB000,
              {16'h2222, 16'h9ABC, 16'h1111, 16'h1234}};
    tv[2] = '{4'b0100, {16'h0000, 16'h0BEE, 16'h0000, 16'h0000}, 1, 16'hA000, 16'hA000,
              {16'h2222, 16'h0BEE, 16'h1111, 16'h1234}};
    tv[3] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h00AA}, 1, 16'h8000, 16'h8000,
              {16'h2222, 16'h0BEE, 16'h1111, 16'h00AA}};
    tv[4] = '{4'b1000, {16'h7777, 16'h0000, 16'h0000, 16'h0000}, 1, 16'hB000, 16'hB000,
              {16'h7777, 16'h0BEE, 16'h1111, 16'h00AA}};

    tick(3);
    rst = 1'b0;
    tick();
    chk("rst_spi_start", 32'(spi_start), 0);
    chk("rst_spi_tx", 32'(spi_tx), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_result_data", 32'(result_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_seq_done", 32'(seq_done), 0);
    chk("rst_aborted", 32'(aborted), 0);
    chk("rst_overrun", 32'(overrun), 0);
    for (int c = 0; c < 4; c++) chk_reg(c, 16'h0, "rst_reg");
    enable = 1'b1;
    tick();

    // Table-driven sequences
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      spi_lat = 3;
      lo = -1; hi = -1;
      for (int c = 0; c < 4; c++) begin
        if (tv[v].mask[c]) begin
          if (lo < 0) lo = c;
          hi = c;
          repeat (NS) rx_q.push_back(tv[v].rx[c]);
        end
      end
      pulse_trigger(tv[v].mask, t0);
      wait_quiet("vec_timeout");
      chk("vec_strobes", 32'(res_data_log.size()), 32'(tv[v].exp_n));
      chk("vec_tx_count", 32'(tx_log.size()), 32'(tv[v].exp_n * NS));
      chk("vec_seq_done", 32'(seq_done_cnt), 1);
      chk("vec_tx_first", 32'((tx_log.size() > 0) ? tx_log[0] : 16'h0), 32'(tv[v].exp_tx0));
      chk("vec_tx_last", 32'((tx_log.size() > 0) ? tx_log[tx_log.size()-1] : 16'h0),
          32'(tv[v].exp_txl));
      chk("vec_start_lat", 32'((tx_cyc.size() > 0) ? tx_cyc[0] - t0 : -1), 32'(2 + lo));
      for (int i = 0; i < res_cyc.size(); i++)
        chk("vec_result_lat", 32'(res_cyc[i] - ((done_cyc.size() >= (i+1)*NS) ?
            done_cyc[(i+1)*NS-1] : 0)), 1);
      chk("vec_hold_ch", 32'(result_ch), 32'(hi));
      chk("vec_hold_data", 32'(result_data), 32'(tv[v].exp_reg[hi]));
      for (int c = 0; c < 4; c++) chk_reg(c, tv[v].exp_reg[c], "vec_reg");
      tick();
    end
    for (int c = 0; c < 4; c++) model_reg[c] = tv[4].exp_reg[c];

    // Randomized sequences against the reference model
    for (int it = 0; it < 16; it++) begin
      clear_logs();
      exp_data.delete(); exp_ch.delete(); exp_tx.delete();
      spi_lat = $urandom_range(1, 5);
      ch_mask = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) begin
        if (ch_mask[c]) begin
          a = 16'($urandom);
          b = 16'($urandom);
          rx_q.push_back(a);
          if (NS == 2) rx_q.push_back(b);
          model_reg[c] = (NS == 2) ? 16'((int'(a) + int'(b)) / 2) : a;
          exp_ch.push_back(c);
          exp_data.push_back(model_reg[c]);
          repeat (NS) exp_tx.push_back(16'(32'h8000 + c * 4096));
        end
      end
      pulse_trigger(ch_mask, t0);
      wait_quiet("rnd_timeout");
      chk("rnd_strobes", 32'(res_data_log.size()), 32'(exp_data.size()));
      chk("rnd_tx_count", 32'(tx_log.size()), 32'(exp_tx.size()));
      for (int i = 0; i < exp_data.size() && i < res_data_log.size(); i++) begin
        chk("rnd_res_ch", 32'(res_ch_log[i]), 32'(exp_ch[i]));
        chk("rnd_res_data", 32'(res_data_log[i]), 32'(exp_data[i]));
      end
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
        chk("rnd_tx", 32'(tx_log[i]), 32'(exp_tx[i]));
      chk("rnd_seq_done", 32'(seq_done_cnt), 1);
      for (int c = 0; c < 4; c++) chk_reg(c, model_reg[c], "rnd_reg");
      tick();
    end

    // Empty mask: seq_done one cycle later, no traffic, never busy
    clear_logs();
    pulse_trigger(4'b0000, t0);
    chk("zmask_busy", 32'(busy), 0);
    tick(3);
    chk("zmask_done_cyc", 32'(seq_done_cyc - t0), 1);
    chk("zmask_done_cnt", 32'(seq_done_cnt), 1);
    chk("zmask_no_tx", 32'(tx_log.size()), 0);

    // Trigger ignored while disabled
    clear_logs();
    enable = 1'b0;
    pulse_trigger(4'b1111, t0);
    tick(4);
    chk("dis_no_tx", 32'(tx_log.size()), 0);
    chk("dis_no_done", 32'(seq_done_cnt), 0);
    chk("dis_busy", 32'(busy), 0);
    enable = 1'b1;

    // Overrun while in WAIT; enable dropped mid-sequence does not stop it
    clear_logs();
    spi_lat = 8;
    repeat (NS) rx_q.push_back(16'h4242);
    pulse_trigger(4'b0001, t0);
    wait_tx(1, "ovr_first_start");
    tick();
    enable = 1'b0;
    pulse_trigger(4'b1111, t0);
    chk("ovr_set", 32'(overrun), 1);
    wait_quiet("ovr_timeout");
    chk("ovr_tx_count", 32'(tx_log.size()), 32'(NS));
    chk("ovr_strobes", 32'(res_data_log.size()), 1);
    chk("ovr_seq_done", 32'(seq_done_cnt), 1);
    chk("ovr_sticky", 32'(overrun), 1);
    model_reg[0] = 16'h4242;
    chk_reg(0, model_reg[0], "ovr_reg0");
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 0);
    enable = 1'b1;

    // Trigger and overrun_clr together while busy: set wins
    clear_logs();
    repeat (NS) rx_q.push_back(16'h4343);
    pulse_trigger(4'b0001, t0);
    wait_tx(1, "ovr2_first_start");
    overrun_clr = 1'b1;
    pulse_trigger(4'b0001, t0);
    overrun_clr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 1);
    wait_quiet("ovr2_timeout");
    model_reg[0] = 16'h4343;
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr2", 32'(overrun), 0);

    // Abort during WAIT of ch2; the late spi_done must be ignored
    clear_logs();
    spi_lat = 6;
    for (int c = 0; c < 4; c++) repeat (NS) rx_q.push_back(16'(32'h0A01 + c));
    pulse_trigger(4'b1111, t0);
    wait_tx(2 * NS + 1, "abt_ch2_start");
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_pulse", 32'(aborted), 1);
    chk("abt_busy", 32'(busy), 0);
    wait_quiet("abt_timeout");
    chk("abt_cnt", 32'(aborted_cnt), 1);
    chk("abt_no_seq_done", 32'(seq_done_cnt), 0);
    chk("abt_strobes", 32'(res_data_log.size()), 2);
    chk("abt_tx_count", 32'(tx_log.size()), 32'(2 * NS + 1));
    model_reg[0] = 16'h0A01;
    model_reg[1] = 16'h0A02;
    for (int c = 0; c < 4; c++) chk_reg(c, model_reg[c], "abt_reg");

    // spi_busy held high for 10 cycles in ISSUE
    clear_logs();
    spi_lat = 2;
    spi_busy = 1'b1;
    repeat (NS) rx_q.push_back(16'h5151);
    pulse_trigger(4'b0001, t0);
    tick(10);
    chk("sbusy_hold", 32'(tx_log.size()), 0);
    spi_busy = 1'b0;
    fall = cyc;
    wait_tx(1, "sbusy_start");
    chk("sbusy_lat", 32'((tx_cyc.size() > 0) ? tx_cyc[0] - fall : -1), 1);
    wait_quiet("sbusy_timeout");
    model_reg[0] = 16'h5151;
    chk_reg(0, model_reg[0], "sbusy_reg0");
    chk("sbusy_seq_done", 32'(seq_done_cnt), 1);

`ifdef ADC_SEQ_AVG_EN
    // Averaging with carry out of the 16-bit sum
    clear_logs();
    rx_q.push_back(16'hFFFF);
    rx_q.push_back(16'hFFFD);
    pulse_trigger(4'b0001, t0);
    wait_quiet("avg_timeout");
    chk("avg_strobes", 32'(res_data_log.size()), 1);
    chk("avg_data", 32'((res_data_log.size() > 0) ? res_data_log[0] : 16'h0), 32'hFFFE);
    chk_reg(0, 16'hFFFE, "avg_reg0");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
